// File: rtl/cva6_tlb_plru.sv
// Fully-associative Sv32 TLB with ASID tags, 4M superpages, tree pseudo-LRU replacement and a registered lookup.
// Optional hit/miss counters are enabled by defining CVA6_TLB_PERF_CNT_EN.
module cva6_tlb_plru #(
  parameter int unsigned TLB_ENTRIES   = 4,
  parameter int unsigned ASID_WIDTH    = 1,
  parameter int unsigned CONTENT_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [ASID_WIDTH-1:0]    asid_to_be_flushed_i,
  input  logic [31:0]              vaddr_to_be_flushed_i,
  input  logic                     update_valid_i,
  input  logic                     update_is_4M_i,
  input  logic [19:0]              update_vpn_i,
  input  logic [ASID_WIDTH-1:0]    update_asid_i,
  input  logic [CONTENT_WIDTH-1:0] update_content_i,
  input  logic                     lu_access_i,
  input  logic [ASID_WIDTH-1:0]    lu_asid_i,
  input  logic [31:0]              lu_vaddr_i,
  output logic                     lu_valid_o,
  output logic                     lu_hit_o,
  output logic                     lu_is_4M_o,
  output logic [CONTENT_WIDTH-1:0] lu_content_o
`ifdef CVA6_TLB_PERF_CNT_EN
  ,
  output logic [31:0]              hit_cnt_o,
  output logic [31:0]              miss_cnt_o
`endif
);

  localparam int unsigned IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam int          NODES = int'(TLB_ENTRIES) - 1;

  typedef struct packed {
    logic                     valid;
    logic [ASID_WIDTH-1:0]    asid;
    logic [9:0]               vpn1;
    logic [9:0]               vpn0;
    logic                     is_4m;
    logic [CONTENT_WIDTH-1:0] content;
  } entry_t;

  entry_t           tags_q [TLB_ENTRIES];
  logic [NODES-1:0] plru_q, plru_d;

  logic [TLB_ENTRIES-1:0] lu_match, flush_sel, upd_match, invalid;
  logic [IDX_W-1:0]       lu_idx, upd_hit_idx, inv_idx, upd_idx;
  logic                   lu_hit_d, upd_en;

  // Node n has children 2n+1 (left, lower indices) and 2n+2; leaves follow the NODES inner nodes.
  function automatic logic [IDX_W-1:0] plru_victim(input logic [NODES-1:0] t);
    int   node;
    logic b;
    node = 0;
    for (int l = 0; l < int'(IDX_W); l++) begin
      b = 1'b0;
      for (int k = 0; k < NODES; k++) if (k == node) b = t[k];
      node = 2 * node + (b ? 2 : 1);
    end
    return IDX_W'(node - NODES);
  endfunction

  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] t,
                                                  input logic [IDX_W-1:0] idx);
    logic [NODES-1:0] r;
    logic [IDX_W-1:0] sh;
    logic             d;
    int               node;
    r    = t;
    node = 0;
    for (int l = 0; l < int'(IDX_W); l++) begin
      sh = idx >> (int'(IDX_W) - 1 - l);
      d  = sh[0];
      for (int k = 0; k < NODES; k++) if (k == node) r[k] = ~d;
      node = 2 * node + (d ? 2 : 1);
    end
    return r;
  endfunction

  always_comb begin
    lu_match  = '0;
    flush_sel = '0;
    upd_match = '0;
    invalid   = '0;
    for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
      lu_match[i] = tags_q[i].valid && (tags_q[i].asid == lu_asid_i) &&
                    (tags_q[i].vpn1 == lu_vaddr_i[31:22]) &&
                    (tags_q[i].is_4m || (tags_q[i].vpn0 == lu_vaddr_i[21:12]));
      flush_sel[i] = ((asid_to_be_flushed_i == '0) || (tags_q[i].asid == asid_to_be_flushed_i)) &&
                     ((vaddr_to_be_flushed_i == '0) ||
                      (tags_q[i].valid && (tags_q[i].vpn1 == vaddr_to_be_flushed_i[31:22]) &&
                       (tags_q[i].is_4m || (tags_q[i].vpn0 == vaddr_to_be_flushed_i[21:12]))));
      upd_match[i] = tags_q[i].valid && (tags_q[i].asid == update_asid_i) &&
                     (tags_q[i].vpn1 == update_vpn_i[19:10]) &&
                     (tags_q[i].is_4m == update_is_4M_i) &&
                     (update_is_4M_i || (tags_q[i].vpn0 == update_vpn_i[9:0]));
      invalid[i] = ~tags_q[i].valid;
    end
  end

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    lu_idx      = '0;
    upd_hit_idx = '0;
    inv_idx     = '0;
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (lu_match[i])  lu_idx      = IDX_W'(i);
      if (upd_match[i]) upd_hit_idx = IDX_W'(i);
      if (invalid[i])   inv_idx     = IDX_W'(i);
    end
  end

  always_comb begin
    upd_en   = update_valid_i && !flush_i;
    lu_hit_d = lu_access_i && (|lu_match) && !flush_i;
    if (|upd_match)    upd_idx = upd_hit_idx;
    else if (|invalid) upd_idx = inv_idx;
    else               upd_idx = plru_victim(plru_q);
  end

  // Lookup touch first, update touch second, so the update owns any shared nodes.
  always_comb begin
    plru_d = plru_q;
    if (lu_hit_d) plru_d = plru_touch(plru_d, lu_idx);
    if (upd_en)   plru_d = plru_touch(plru_d, upd_idx);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      plru_q <= '0;
      for (int i = 0; i < int'(TLB_ENTRIES); i++) tags_q[i] <= '0;
    end else begin
      plru_q <= plru_d;
      for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
        if (flush_i && flush_sel[i]) begin
          tags_q[i].valid <= 1'b0;
        end else if (upd_en && (upd_idx == IDX_W'(i))) begin
          tags_q[i] <= '{valid: 1'b1, asid: update_asid_i, vpn1: update_vpn_i[19:10],
                         vpn0: update_vpn_i[9:0], is_4m: update_is_4M_i,
                         content: update_content_i};
        end
      end
    end
  end

  // Lookup is valid-only: lu_access_i is never back-pressured and lu_valid_o pulses one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_valid_o   <= 1'b0;
      lu_hit_o     <= 1'b0;
      lu_is_4M_o   <= 1'b0;
      lu_content_o <= '0;
    end else begin
      lu_valid_o   <= lu_access_i;
      lu_hit_o     <= lu_hit_d;
      lu_is_4M_o   <= lu_hit_d ? tags_q[lu_idx].is_4m : 1'b0;
      lu_content_o <= lu_hit_d ? tags_q[lu_idx].content : '0;
    end
  end

`ifdef CVA6_TLB_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (lu_valid_o) begin
      if (lu_hit_o && (hit_cnt_o != 32'hFFFF_FFFF))   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (!lu_hit_o && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
